// File: rtl/fco_align_wren_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fco_align_wren_ctrl_if
//  Description : Bundle of the FCO aligner / FIFO write-enable controller
//                control, lane and status signals.
//                master : the controller (drives slip/lock/status/wren)
//                slave  : the surrounding logic (drives lanes, enables, full)
//                The lock_loss_cnt member exists only when FCO_LOSS_CNT_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface fco_align_wren_ctrl_if #(
    parameter int N_CH    = 2,
    parameter int FRAME_W = 14
);
    logic                      clk_en;
    logic                      enable;
    logic [N_CH*FRAME_W-1:0]   fco_pattern;
    logic                      data_fifo_full;
    logic [N_CH-1:0]           bit_slip;
    logic [N_CH-1:0]           ch_locked;
    logic [N_CH-1:0]           align_fail;
    logic                      all_locked;
    logic                      data_fifo_wren;
    logic [3:0]                state_wren;
`ifdef FCO_LOSS_CNT_EN
    logic [15:0]               lock_loss_cnt;
`endif

    modport master (
        input  clk_en,
        input  enable,
        input  fco_pattern,
        input  data_fifo_full,
        output bit_slip,
        output ch_locked,
        output align_fail,
        output all_locked,
        output data_fifo_wren,
        output state_wren
`ifdef FCO_LOSS_CNT_EN
        , output lock_loss_cnt
`endif
    );

    modport slave (
        output clk_en,
        output enable,
        output fco_pattern,
        output data_fifo_full,
        input  bit_slip,
        input  ch_locked,
        input  align_fail,
        input  all_locked,
        input  data_fifo_wren,
        input  state_wren
`ifdef FCO_LOSS_CNT_EN
        , input lock_loss_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fco_align_wren_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fco_align_wren_ctrl
//  Description : Multi-channel frame-clock (FCO) aligner and data FIFO
//                write-enable controller for the ADC deserialiser path.
//                Each lane's FCO word is compared to FCO_PATTERN; unlocked,
//                mismatching lanes get a one-cycle bit_slip every
//                SLIP_WAIT+1 clk_en cycles. Lock uses hit/miss hysteresis.
//                Once every lane is locked and a settle delay has passed,
//                FIFO writes are enabled while the FIFO is not full.
//  Ports       : ad_dco_fc  - clock (frame-rate divided DCO)
//                reset      - asynchronous, active-high
//                bus        - fco_align_wren_ctrl_if.master:
//                  clk_en, enable, fco_pattern, data_fifo_full (in)
//                  bit_slip, ch_locked, align_fail, all_locked,
//                  data_fifo_wren, state_wren [, lock_loss_cnt] (out)
//  Options     : FCO_LOSS_CNT_EN - adds the saturating 16-bit lock_loss_cnt
//                that counts WORK/OVER->IDLE exits caused by lock loss.
//  Revision    : 1.0  initial release
// ============================================================================
module fco_align_wren_ctrl #(
    parameter int                 FRAME_W       = 14,
    parameter logic [FRAME_W-1:0] FCO_PATTERN   = 14'h3F80,
    parameter int                 N_CH          = 2,
    parameter int                 SLIP_WAIT     = 4,
    parameter int                 SETTLE        = 4,
    parameter int                 LOCK_HITS     = 2,
    parameter int                 UNLOCK_MISSES = 3
) (
    input  logic                   ad_dco_fc,
    input  logic                   reset,
    fco_align_wren_ctrl_if.master  bus
);
    localparam int HIT_W    = $clog2(LOCK_HITS + 1);
    localparam int MISS_W   = $clog2(UNLOCK_MISSES + 1);
    localparam int WAIT_W   = $clog2(SLIP_WAIT + 1);
    localparam int SLIP_W   = $clog2(FRAME_W + 1);
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    localparam logic [HIT_W-1:0]    HIT_MAX     = HIT_W'(LOCK_HITS);
    localparam logic [MISS_W-1:0]   MISS_MAX    = MISS_W'(UNLOCK_MISSES);
    localparam logic [WAIT_W-1:0]   WAIT_MAX    = WAIT_W'(SLIP_WAIT);
    localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(FRAME_W);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_WORK = 4'b0100,
        ST_OVER = 4'b1000
    } state_t;

    logic [N_CH-1:0] slip_vec;
    logic [N_CH-1:0] locked_vec;
    logic [N_CH-1:0] fail_vec;
    logic            all_locked;

    // ------------------------------------------------------------------------
    // Per-lane lock hysteresis and slip engine
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic                match;
        logic                slip_now;
        logic [HIT_W-1:0]    hit_cnt_q,  hit_cnt_d;
        logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
        logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
        logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
        logic                ch_locked_q, ch_locked_d;
        logic                align_fail_q, align_fail_d;

        assign match = (bus.fco_pattern[c*FRAME_W +: FRAME_W] == FCO_PATTERN);

        // Combinational so the pulse can never outlive its clk_en cycle and
        // vanishes together with the counters on an asynchronous reset.
        assign slip_now = bus.enable & bus.clk_en & (wait_cnt_q == WAIT_MAX) &
                          ~ch_locked_q & ~match & ~align_fail_q;

        always_comb begin
            hit_cnt_d   = hit_cnt_q;
            miss_cnt_d  = miss_cnt_q;
            ch_locked_d = ch_locked_q;
            if (match) begin
                miss_cnt_d = '0;
                if (hit_cnt_q != HIT_MAX) begin
                    hit_cnt_d = hit_cnt_q + 1'b1;
                end
                if (hit_cnt_d == HIT_MAX) begin
                    ch_locked_d = 1'b1;
                end
            end else begin
                hit_cnt_d = '0;
                if (miss_cnt_q != MISS_MAX) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
                if (miss_cnt_d == MISS_MAX) begin
                    ch_locked_d = 1'b0;
                end
            end
        end

        always_comb begin
            wait_cnt_d   = wait_cnt_q;
            slip_cnt_d   = slip_cnt_q;
            align_fail_d = align_fail_q;
            if (!bus.enable) begin
                // Dropping enable re-arms the lane for a fresh alignment.
                wait_cnt_d   = '0;
                slip_cnt_d   = '0;
                align_fail_d = 1'b0;
            end else if (bus.clk_en) begin
                if (wait_cnt_q == WAIT_MAX) begin
                    wait_cnt_d = '0;
                    if (slip_now) begin
                        slip_cnt_d = slip_cnt_q + 1'b1;
                        // A full word of slips without a match: give up.
                        if (slip_cnt_d == SLIP_MAX) begin
                            align_fail_d = 1'b1;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge ad_dco_fc or posedge reset) begin
            if (reset) begin
                hit_cnt_q    <= '0;
                miss_cnt_q   <= '0;
                wait_cnt_q   <= '0;
                slip_cnt_q   <= '0;
                ch_locked_q  <= 1'b0;
                align_fail_q <= 1'b0;
            end else begin
                hit_cnt_q    <= hit_cnt_d;
                miss_cnt_q   <= miss_cnt_d;
                wait_cnt_q   <= wait_cnt_d;
                slip_cnt_q   <= slip_cnt_d;
                ch_locked_q  <= ch_locked_d;
                align_fail_q <= align_fail_d;
            end
        end

        assign slip_vec[c]   = slip_now;
        assign locked_vec[c] = ch_locked_q;
        assign fail_vec[c]   = align_fail_q;
    end

    assign all_locked = &locked_vec;

    // ------------------------------------------------------------------------
    // Write-enable FSM
    // ------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                settle_cnt_d = '0;
                if (bus.enable && all_locked) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Compared against SETTLE-1 so WAIT lasts exactly SETTLE cycles.
                if (!bus.enable || !all_locked) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_WORK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_WORK: begin
                if (!bus.enable || !all_locked) begin
                    state_d = ST_IDLE;
                end else if (bus.data_fifo_full) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (!bus.enable || !all_locked) begin
                    state_d = ST_IDLE;
                end else if (!bus.data_fifo_full) begin
                    state_d = ST_WORK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ad_dco_fc or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef FCO_LOSS_CNT_EN
    // Lock loss has priority over every other exit from WORK/OVER, so being
    // in either state with all_locked low is exactly a lock-loss exit.
    logic        loss_evt;
    logic [15:0] lock_loss_cnt_q, lock_loss_cnt_d;

    assign loss_evt = ((state_q == ST_WORK) || (state_q == ST_OVER)) && !all_locked;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (loss_evt && (lock_loss_cnt_q != 16'hFFFF)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ad_dco_fc or posedge reset) begin
        if (reset) begin
            lock_loss_cnt_q <= '0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign bus.lock_loss_cnt = lock_loss_cnt_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.bit_slip       = slip_vec;
    assign bus.ch_locked      = locked_vec;
    assign bus.align_fail     = fail_vec;
    assign bus.all_locked     = all_locked;
    assign bus.state_wren     = state_q;
    // Combinational on full so a write is never issued into a full FIFO.
    assign bus.data_fifo_wren = (state_q == ST_WORK) && !bus.data_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_fco_align_wren_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fco_align_wren_ctrl
//  Description : Scenario bench for fco_align_wren_ctrl (FRAME_W=14, N_CH=2,
//                default timing parameters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fco_align_wren_ctrl;
    localparam int         N_CH    = 2;
    localparam int         FRAME_W = 14;
    localparam logic [13:0] PAT    = 14'h3F80;
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_WAIT  = 4'b0010;
    localparam logic [3:0] S_WORK  = 4'b0100;
    localparam logic [3:0] S_OVER  = 4'b1000;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] lk;
        logic       wren;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] lane0, lane1;
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    exp_t        exp_q[$];
    int          slip_q[$];

    always #5 clk = ~clk;

    fco_align_wren_ctrl_if #(.N_CH(N_CH), .FRAME_W(FRAME_W)) bus ();
    assign bus.fco_pattern = {lane1, lane0};

    fco_align_wren_ctrl #(
        .FRAME_W(FRAME_W), .FCO_PATTERN(PAT), .N_CH(N_CH), .SLIP_WAIT(4),
        .SETTLE(4), .LOCK_HITS(2), .UNLOCK_MISSES(3)
    ) dut (
        .ad_dco_fc(clk),
        .reset    (reset),
        .bus      (bus)
    );

    function automatic exp_t obs();
        return {bus.state_wren, bus.ch_locked, bus.data_fifo_wren};
    endfunction

    function automatic logic [11:0] all_outs();
        return {bus.state_wren, bus.bit_slip, bus.ch_locked, bus.align_fail,
                bus.all_locked, bus.data_fifo_wren};
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic [1:0] lk, input logic w);
        exp_t e;
        e.st = st; e.lk = lk; e.wren = w;
        return e;
    endfunction

    // Inputs change 1 ns after the rising edge; outputs are sampled on the
    // falling edge of the same cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.clk_en = 1'b1;
        bus.data_fifo_full = 1'b0;
        lane0 = PAT;
        lane1 = PAT;
        exp_q.delete();
        slip_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.clk_en = 1'b1;
        bus.data_fifo_full = 1'b0;
        lane0 = PAT;
        lane1 = PAT;
        #2;
        n_total++;
        if (all_outs() !== 12'b0001_00_00_00_0_0)
            $display("FAIL reset_outputs: got %b expected %b", all_outs(), 12'b0001_00_00_00_0_0);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (all_outs() !== 12'b0001_00_00_00_0_0)
            $display("FAIL reset_held: got %b expected %b", all_outs(), 12'b0001_00_00_00_0_0);
        else n_pass++;
`ifdef FCO_LOSS_CNT_EN
        n_total++;
        if (bus.lock_loss_cnt !== 16'd0)
            $display("FAIL reset_loss_cnt: got %0d expected 0", bus.lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_lock_basic();
        int   slips = 0;
        exp_t e, got;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q.push_back(mk((i <= 2) ? S_IDLE : (i <= 6) ? S_WAIT : S_WORK,
                               (i >= 2) ? 2'b11 : 2'b00, (i >= 7)));
            @(negedge clk);
            if (bus.bit_slip !== 2'b00) slips++;
            got = obs();
            e   = exp_q.pop_front();
            n_total++;
            if (got !== e)
                $display("FAIL lock_basic cyc %0d: got st=%b lk=%b wren=%b expected st=%b lk=%b wren=%b",
                         cyc, got.st, got.lk, got.wren, e.st, e.lk, e.wren);
            else n_pass++;
        end
        n_total++;
        if (slips !== 0) $display("FAIL lock_basic_noslip: got %0d pulses expected 0", slips);
        else n_pass++;
    endtask

    task automatic test_slip_lane1();
        logic [13:0] p;
        int   s0 = 0;
        logic pend = 1'b0;
        int   ec;
        exp_t got;
        do_reset();
        p = PAT;
        lane1 = {p[10:0], p[13:11]};
        slip_q.push_back(4);
        slip_q.push_back(9);
        slip_q.push_back(14);
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (pend) begin
                lane1 = {lane1[0], lane1[13:1]};
                pend = 1'b0;
            end
            @(negedge clk);
            if (bus.bit_slip[0]) s0++;
            if (bus.bit_slip[1]) begin
                pend = 1'b1;
                n_total++;
                if (slip_q.size() == 0) begin
                    $display("FAIL slip1_unexpected: got pulse at cyc %0d expected none", cyc);
                end else begin
                    ec = slip_q.pop_front();
                    if (cyc !== ec) $display("FAIL slip1_time: got cyc %0d expected cyc %0d", cyc, ec);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (slip_q.size() != 0) $display("FAIL slip1_missing: got %0d outstanding expected 0", slip_q.size());
        else n_pass++;
        n_total++;
        if (s0 !== 0) $display("FAIL slip0_quiet: got %0d pulses expected 0", s0);
        else n_pass++;
        got = obs();
        n_total++;
        if (got !== mk(S_WORK, 2'b11, 1'b1))
            $display("FAIL slip1_work: got st=%b lk=%b wren=%b expected st=%b lk=11 wren=1",
                     got.st, got.lk, got.wren, S_WORK);
        else n_pass++;
    endtask

    task automatic test_align_fail();
        int   s1 = 0;
        int   bad = 0;
        int   ec;
        logic [1:0] ef;
        do_reset();
        lane0 = 14'h0000;
        for (int k = 0; k < 14; k++) slip_q.push_back(4 + 5 * k);
        for (int i = 1; i <= 90; i++) begin
            tick();
            @(negedge clk);
            if (bus.bit_slip[1]) s1++;
            if (bus.bit_slip[0]) begin
                n_total++;
                if (slip_q.size() == 0) begin
                    $display("FAIL fail_extra_slip: got pulse at cyc %0d expected none", cyc);
                end else begin
                    ec = slip_q.pop_front();
                    if (cyc !== ec) $display("FAIL fail_slip_time: got cyc %0d expected cyc %0d", cyc, ec);
                    else n_pass++;
                end
            end
            if (i == 69 || i == 70) begin
                ef = (i == 70) ? 2'b01 : 2'b00;
                n_total++;
                if (bus.align_fail !== ef)
                    $display("FAIL align_fail_cyc%0d: got %b expected %b", i, bus.align_fail, ef);
                else n_pass++;
            end
        end
        n_total++;
        if (slip_q.size() != 0 || s1 != 0)
            $display("FAIL fail_slip_count: got %0d missing lane0, %0d lane1 pulses expected 0/0",
                     slip_q.size(), s1);
        else n_pass++;
        n_total++;
        if (bus.state_wren !== S_IDLE || bus.data_fifo_wren !== 1'b0)
            $display("FAIL fail_idle: got st=%b wren=%b expected st=%b wren=0",
                     bus.state_wren, bus.data_fifo_wren, S_IDLE);
        else n_pass++;
        // Re-arm with an enable pulse, then hold clk_en low.
        tick();
        bus.enable = 1'b0;
        @(negedge clk);
        tick();
        bus.enable = 1'b1;
        bus.clk_en = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.align_fail !== 2'b00) $display("FAIL rearm: got align_fail=%b expected 00", bus.align_fail);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (bus.bit_slip !== 2'b00) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL clk_en_gate: got %0d pulses expected 0", bad);
        else n_pass++;
        tick();
        bus.clk_en = 1'b1;
        slip_q.push_back(cyc + 4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.bit_slip[0]) begin
                n_total++;
                if (slip_q.size() == 0) begin
                    $display("FAIL resume_extra: got pulse at cyc %0d expected none", cyc);
                end else begin
                    ec = slip_q.pop_front();
                    if (cyc !== ec) $display("FAIL resume_time: got cyc %0d expected cyc %0d", cyc, ec);
                    else n_pass++;
                end
            end
            tick();
        end
        n_total++;
        if (slip_q.size() != 0) $display("FAIL resume_missing: got %0d outstanding expected 0", slip_q.size());
        else n_pass++;
    endtask

    task automatic run_scoreboard(input string name);
        exp_t e, got;
        @(negedge clk);
        got = obs();
        e   = exp_q.pop_front();
        n_total++;
        if (got !== e)
            $display("FAIL %s cyc %0d: got st=%b lk=%b wren=%b expected st=%b lk=%b wren=%b",
                     name, cyc, got.st, got.lk, got.wren, e.st, e.lk, e.wren);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        repeat (8) tick();
        tick(); bus.data_fifo_full = 1'b1; exp_q.push_back(mk(S_WORK, 2'b11, 1'b0));
        run_scoreboard("full_same_cycle");
        for (int i = 0; i < 9; i++) begin
            tick(); exp_q.push_back(mk(S_OVER, 2'b11, 1'b0));
            run_scoreboard("full_over");
        end
        tick(); bus.data_fifo_full = 1'b0; exp_q.push_back(mk(S_OVER, 2'b11, 1'b0));
        run_scoreboard("full_release");
        tick(); exp_q.push_back(mk(S_WORK, 2'b11, 1'b1));
        run_scoreboard("full_back_work");
        // Unlock and full arriving together must exit to IDLE, not OVER.
        for (int i = 0; i < 3; i++) begin
            tick(); lane0 = 14'h0000; exp_q.push_back(mk(S_WORK, 2'b11, 1'b1));
            run_scoreboard("unlock_full_pre");
        end
        tick(); lane0 = PAT; bus.data_fifo_full = 1'b1; exp_q.push_back(mk(S_WORK, 2'b10, 1'b0));
        run_scoreboard("unlock_full_drop");
        tick(); exp_q.push_back(mk(S_IDLE, 2'b10, 1'b0));
        run_scoreboard("unlock_full_idle");
    endtask

    task automatic test_unlock();
        logic [3:0] st;
        logic [1:0] lk;
        do_reset();
        repeat (8) tick();
        for (int c = 0; c <= 12; c++) begin
            tick();
            lane0 = (c == 0 || c == 1 || (c >= 6 && c <= 8)) ? 14'h0000 : PAT;
            st = (c <= 9) ? S_WORK : (c <= 11) ? S_IDLE : S_WAIT;
            lk = (c == 9 || c == 10) ? 2'b10 : 2'b11;
            exp_q.push_back(mk(st, lk, (c <= 9)));
            run_scoreboard("unlock");
        end
`ifdef FCO_LOSS_CNT_EN
        n_total++;
        if (bus.lock_loss_cnt !== 16'd1)
            $display("FAIL loss_cnt: got %0d expected 1", bus.lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8) tick();
        @(negedge clk);
        #1;
        n_total++;
        if (bus.data_fifo_wren !== 1'b1) $display("FAIL areset_pre_work: got wren=%b expected 1", bus.data_fifo_wren);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (all_outs() !== 12'b0001_00_00_00_0_0)
            $display("FAIL areset_work: got %b expected %b", all_outs(), 12'b0001_00_00_00_0_0);
        else n_pass++;
        do_reset();
        repeat (8) tick();
        tick(); bus.data_fifo_full = 1'b1;
        tick();
        @(negedge clk);
        #1;
        n_total++;
        if (bus.state_wren !== S_OVER) $display("FAIL areset_pre_over: got st=%b expected %b", bus.state_wren, S_OVER);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (all_outs() !== 12'b0001_00_00_00_0_0)
            $display("FAIL areset_over: got %b expected %b", all_outs(), 12'b0001_00_00_00_0_0);
        else n_pass++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_basic();
        test_slip_lane1();
        test_align_fail();
        test_fifo_full();
        test_unlock();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
